// File: rtl/display_pkg.sv
// Shared constants, scan state encoding and digit-drive helpers for the
// 4-digit multiplexed 7-segment display path.
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_ZERO   = 7'h3F;
    localparam logic [7:0] SEG_DARK   = 8'hFF;
    localparam logic [3:0] AN_DARK    = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ON   = 2'd2,
        GAP  = 2'd3
    } scan_state_t;

    // Active-low anode for digit idx; digit 0 (leftmost) sits on an[3].
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        anode_for = ~(4'b1000 >> idx);
    endfunction

    // Active-low cathodes from an active-high pattern plus forced dp.
    function automatic logic [7:0] cathode_for(input logic [7:0] seg, input logic dp);
        cathode_for = ~(seg | {dp, 7'b000_0000});
    endfunction

endpackage

// File: rtl/seg_scan_driver_scan_timer.sv
// Loadable down-counter with terminal-count flag; times both the lit
// slot and the inter-digit gap. Holds at zero once it gets there.
module scan_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Reload on state entry, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with frame-coherent
// input snapshot, dp override, leading-zero blanking and ghosting gap.
//
//   state | meaning
//   IDLE  | display dark, waiting for enable
//   LOAD  | one dark cycle; snapshot inputs and blank flags, idx=0
//   ON    | digit idx lit (or dark if blanked) for DIGIT_CYCLES
//   GAP   | all dark for BLANK_CYCLES between digits
module seg_scan_driver
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [7:0] seg_out,
    output logic       frame_tick
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    scan_state_t r_state;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [7:0]  r_seg_out;
    logic        r_frame_tick;
    logic [7:0]  r_seg_s [NUM_DIGITS];
    logic [3:0]  r_dp_s;
    logic [3:0]  r_blank_s;

    logic [7:0]  w_seg_in [NUM_DIGITS];
    logic [3:0]  w_blank_in;
    logic        w_lead;
    logic        w_tc;
    logic        w_last;
    logic        w_enter_on;
    logic        w_enter_gap;
    logic [1:0]  w_next_idx;
    logic [3:0]  w_adv_an;
    logic [7:0]  w_adv_seg;

    assign w_seg_in[0] = seg0;
    assign w_seg_in[1] = seg1;
    assign w_seg_in[2] = seg2;
    assign w_seg_in[3] = seg3;

    // Leading-zero blank flags from live inputs; only latched in LOAD.
    // Digit 3 is never blanked so a value of zero still shows one "0".
    always_comb begin
        w_lead     = 1'b1;
        w_blank_in = 4'b0000;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            w_lead        = w_lead & (w_seg_in[i][6:0] == SEG_ZERO) & ~dp_mask[i];
            w_blank_in[i] = blank_lz & w_lead;
        end
    end

    assign w_last     = (r_idx == 2'd3);
    assign w_next_idx = r_idx + 2'd1;

    // Drive values for the digit after idx, taken from the shadow copy.
    always_comb begin
        w_adv_an  = anode_for(w_next_idx);
        w_adv_seg = cathode_for(r_seg_s[w_next_idx], r_dp_s[w_next_idx]);
        if (r_blank_s[w_next_idx]) begin
            w_adv_an  = AN_DARK;
            w_adv_seg = SEG_DARK;
        end
    end

    assign w_enter_gap = (r_state == ON) && w_tc && (BLANK_CYCLES > 0);
    assign w_enter_on  = (r_state == LOAD) ||
                         (w_tc && !w_last && (((r_state == ON) && (BLANK_CYCLES == 0)) ||
                                              (r_state == GAP)));

    scan_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (~enable),
        .i_load     (w_enter_on | w_enter_gap),
        .i_load_val (w_enter_gap ? GAP_LOAD : ON_LOAD),
        .o_tc       (w_tc)
    );

    // Scan FSM; outputs are registered alongside the state they belong to
    // so anode and cathode always switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_an         <= AN_DARK;
            r_seg_out    <= SEG_DARK;
            r_frame_tick <= 1'b0;
            r_dp_s       <= 4'b0000;
            r_blank_s    <= 4'b0000;
            for (int i = 0; i < NUM_DIGITS; i++) r_seg_s[i] <= 8'h00;
        end else if (!enable) begin
            r_state      <= IDLE;
            r_idx        <= 2'd0;
            r_an         <= AN_DARK;
            r_seg_out    <= SEG_DARK;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state   <= LOAD;
                    r_an      <= AN_DARK;
                    r_seg_out <= SEG_DARK;
                end
                LOAD: begin
                    for (int i = 0; i < NUM_DIGITS; i++) r_seg_s[i] <= w_seg_in[i];
                    r_dp_s       <= dp_mask;
                    r_blank_s    <= w_blank_in;
                    r_idx        <= 2'd0;
                    r_state      <= ON;
                    r_frame_tick <= 1'b1;
                    if (w_blank_in[0]) begin
                        r_an      <= AN_DARK;
                        r_seg_out <= SEG_DARK;
                    end else begin
                        r_an      <= anode_for(2'd0);
                        r_seg_out <= cathode_for(seg0, dp_mask[0]);
                    end
                end
                ON: begin
                    if (w_tc) begin
                        if (BLANK_CYCLES > 0) begin
                            r_state   <= GAP;
                            r_an      <= AN_DARK;
                            r_seg_out <= SEG_DARK;
                        end else if (w_last) begin
                            r_state   <= LOAD;
                            r_an      <= AN_DARK;
                            r_seg_out <= SEG_DARK;
                        end else begin
                            r_state   <= ON;
                            r_idx     <= w_next_idx;
                            r_an      <= w_adv_an;
                            r_seg_out <= w_adv_seg;
                        end
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        if (w_last) begin
                            r_state   <= LOAD;
                            r_an      <= AN_DARK;
                            r_seg_out <= SEG_DARK;
                        end else begin
                            r_state   <= ON;
                            r_idx     <= w_next_idx;
                            r_an      <= w_adv_an;
                            r_seg_out <= w_adv_seg;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_an      <= AN_DARK;
                    r_seg_out <= SEG_DARK;
                end
            endcase
        end
    end

    assign an         = r_an;
    assign seg_out    = r_seg_out;
    assign frame_tick = r_frame_tick;

endmodule
